smo_pair_scheduler: RTL

- Outer-loop controller for SMO training. Repeatedly scans per-vector score/flag memory, selects the maximal-violating pair (i, j), launches the alpha-update calculator, and writes new alphas back.
- Terminates on convergence (gap <= TOL) or on MAX_ITER iterations.
- Sits between the dataset-init controller (which fills the label/alpha/type/grad RAMs) and the alpha-update datapath.

---
 rtl/smo_pair_scheduler_pkg.sv | 19 +
 rtl/smo_pair_scheduler_if.sv | 45 ++++
 rtl/smo_pair_scheduler_tracker.sv | 63 ++++++
 rtl/smo_pair_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/smo_pair_scheduler_pkg.sv
// smo_pkg: shared widths, state encoding and score limits for the SMO pair scheduler.
package smo_pkg;
    localparam int IDX_W = 11;
    localparam int DATA_W = 64;
    localparam int CAL_TIMEOUT_DEF = 4096;
    localparam logic signed [DATA_W-1:0] TOL_DEF = 64'h0000_0000_0010_0000;
    localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] SCORE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    typedef enum logic [7:0] {
        S_IDLE   = 8'h01,
        S_SCAN   = 8'h02,
        S_EVAL   = 8'h04,
        S_LAUNCH = 8'h08,
        S_WAIT   = 8'h10,
        S_WB1    = 8'h20,
        S_WB2    = 8'h40,
        S_DONE   = 8'h80
    } state_e;
endpackage

// File: rtl/smo_pair_scheduler_if.sv
// smo_pair_scheduler_if: scheduler links to score RAM, alpha calculator and alpha RAM.
// cal_err exists only when SMO_CAL_WATCHDOG_EN is defined.
interface smo_pair_scheduler_if;
    import smo_pkg::*;
    logic                     start;
    logic [IDX_W-1:0]         n_vector;
    logic                     rd_en;
    logic [IDX_W-1:0]         rd_addr;
    logic signed [DATA_W-1:0] rd_score;
    logic                     rd_up;
    logic                     rd_low;
    logic                     cal_start;
    logic [IDX_W-1:0]         i_idx;
    logic [IDX_W-1:0]         j_idx;
    logic                     cal_finish;
    logic [DATA_W-1:0]        new_a1;
    logic [DATA_W-1:0]        new_a2;
    logic                     a_wr_en;
    logic [IDX_W-1:0]         a_wr_addr;
    logic [DATA_W-1:0]        a_wr_data;
    logic                     busy;
    logic                     finish;
    logic                     converged;
    logic                     timeout;
    logic [15:0]              iter_count;
`ifdef SMO_CAL_WATCHDOG_EN
    logic                     cal_err;
`endif
    modport master (
        input  start, n_vector, rd_score, rd_up, rd_low, cal_finish, new_a1, new_a2,
        output rd_en, rd_addr, cal_start, i_idx, j_idx, a_wr_en, a_wr_addr, a_wr_data,
               busy, finish, converged, timeout, iter_count
`ifdef SMO_CAL_WATCHDOG_EN
        , cal_err
`endif
    );
    modport slave (
        output start, n_vector, rd_score, rd_up, rd_low, cal_finish, new_a1, new_a2,
        input  rd_en, rd_addr, cal_start, i_idx, j_idx, a_wr_en, a_wr_addr, a_wr_data,
               busy, finish, converged, timeout, iter_count
`ifdef SMO_CAL_WATCHDOG_EN
        , cal_err
`endif
    );
endinterface

// File: rtl/smo_pair_scheduler_tracker.sv
// smo_extreme_tracker: streaming argmax over I_up and argmin over I_low; strict compare keeps the lower index on ties.
module smo_extreme_tracker
    import smo_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     clr_i,
    input  logic                     vld_i,
    input  logic [IDX_W-1:0]         idx_i,
    input  logic signed [DATA_W-1:0] score_i,
    input  logic                     up_i,
    input  logic                     low_i,
    output logic signed [DATA_W-1:0] max_up_o,
    output logic signed [DATA_W-1:0] min_low_o,
    output logic [IDX_W-1:0]         idx_up_o,
    output logic [IDX_W-1:0]         idx_low_o,
    output logic                     have_up_o,
    output logic                     have_low_o
);
    logic signed [DATA_W-1:0] max_q, min_q;
    logic [IDX_W-1:0]         iup_q, ilow_q;
    logic                     hup_q, hlow_q;
    logic                     upd_up, upd_low;

    always_comb begin
        upd_up  = vld_i && up_i && score_i > max_q;
        upd_low = vld_i && low_i && score_i < min_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            max_q  <= '0;
            min_q  <= '0;
            iup_q  <= '0;
            ilow_q <= '0;
            hup_q  <= 1'b0;
            hlow_q <= 1'b0;
        end else if (clr_i) begin
            max_q  <= SCORE_MIN;
            min_q  <= SCORE_MAX;
            hup_q  <= 1'b0;
            hlow_q <= 1'b0;
        end else begin
            if (upd_up) begin
                max_q <= score_i;
                iup_q <= idx_i;
                hup_q <= 1'b1;
            end
            if (upd_low) begin
                min_q  <= score_i;
                ilow_q <= idx_i;
                hlow_q <= 1'b1;
            end
        end
    end

    assign max_up_o   = max_q;
    assign min_low_o  = min_q;
    assign idx_up_o   = iup_q;
    assign idx_low_o  = ilow_q;
    assign have_up_o  = hup_q;
    assign have_low_o = hlow_q;
endmodule

// File: rtl/smo_pair_scheduler.sv
// smo_pair_scheduler: SMO outer loop - scan scores, pick max-violating pair, launch calculator, write alphas back.
// Optional calculator watchdog (cal_err) enabled by SMO_CAL_WATCHDOG_EN.
module smo_pair_scheduler
    import smo_pkg::*;
#(
    parameter logic signed [DATA_W-1:0] TOL = TOL_DEF,
    parameter logic [15:0] MAX_ITER = 16'd1000
`ifdef SMO_CAL_WATCHDOG_EN
    , parameter int CAL_TIMEOUT = CAL_TIMEOUT_DEF
`endif
) (
    input logic                  clk,
    input logic                  rst_,
    smo_pair_scheduler_if.master bus
);
    localparam logic signed [DATA_W:0] TOL_X = {TOL[DATA_W-1], TOL};

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         n_q, n_d, cnt_q, cnt_d, i_q, i_d, j_q, j_d, vidx_q;
    logic [DATA_W-1:0]        a1_q, a1_d, a2_q, a2_d;
    logic [15:0]              iter_q, iter_d;
    logic                     conv_q, conv_d, tmo_q, tmo_d;
    logic                     vld_q, clr, rd_en;
    logic [IDX_W-1:0]         rd_addr, idx_up, idx_low;
    logic signed [DATA_W-1:0] max_up, min_low;
    logic                     have_up, have_low;
    logic signed [DATA_W:0]   gap;
`ifdef SMO_CAL_WATCHDOG_EN
    logic [31:0]              wd_q, wd_d;
    logic                     err_q, err_d;
`endif

    smo_extreme_tracker u_trk (
        .clk       (clk),
        .rst_      (rst_),
        .clr_i     (clr),
        .vld_i     (vld_q),
        .idx_i     (vidx_q),
        .score_i   (bus.rd_score),
        .up_i      (bus.rd_up),
        .low_i     (bus.rd_low),
        .max_up_o  (max_up),
        .min_low_o (min_low),
        .idx_up_o  (idx_up),
        .idx_low_o (idx_low),
        .have_up_o (have_up),
        .have_low_o(have_low)
    );

    // Sign-extend to 65 bits so extreme scores cannot wrap the gap.
    assign gap     = $signed({max_up[DATA_W-1], max_up}) - $signed({min_low[DATA_W-1], min_low});
    assign rd_en   = state_q == S_SCAN && cnt_q < n_q;
    assign rd_addr = rd_en ? cnt_q : '0;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        j_d     = j_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        iter_d  = iter_q;
        conv_d  = conv_q;
        tmo_d   = tmo_q;
        clr     = 1'b0;
`ifdef SMO_CAL_WATCHDOG_EN
        wd_d    = wd_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: if (bus.start) begin
                n_d     = bus.n_vector;
                cnt_d   = '0;
                iter_d  = '0;
                tmo_d   = 1'b0;
                conv_d  = bus.n_vector == '0;
                clr     = 1'b1;
                state_d = bus.n_vector == '0 ? S_DONE : S_SCAN;
`ifdef SMO_CAL_WATCHDOG_EN
                err_d   = 1'b0;
`endif
            end
            S_SCAN: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == n_q ? S_EVAL : S_SCAN;
            end
            S_EVAL: if (!have_up || !have_low || gap <= TOL_X) begin
                conv_d  = 1'b1;
                state_d = S_DONE;
            end else begin
                i_d     = idx_up;
                j_d     = idx_low;
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
`ifdef SMO_CAL_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: if (bus.cal_finish) begin
                a1_d    = bus.new_a1;
                a2_d    = bus.new_a2;
                state_d = S_WB1;
            end
`ifdef SMO_CAL_WATCHDOG_EN
            else if (wd_q == 32'(CAL_TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = S_DONE;
            end else begin
                wd_d    = wd_q + 1'b1;
            end
`endif
            S_WB1: state_d = S_WB2;
            S_WB2: begin
                iter_d  = iter_q + 16'd1;
                tmo_d   = iter_d == MAX_ITER;
                cnt_d   = '0;
                clr     = iter_d != MAX_ITER;
                state_d = iter_d == MAX_ITER ? S_DONE : S_SCAN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            iter_q  <= '0;
            conv_q  <= 1'b0;
            tmo_q   <= 1'b0;
            vld_q   <= 1'b0;
            vidx_q  <= '0;
`ifdef SMO_CAL_WATCHDOG_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            iter_q  <= iter_d;
            conv_q  <= conv_d;
            tmo_q   <= tmo_d;
            vld_q   <= rd_en;
            vidx_q  <= rd_addr;
`ifdef SMO_CAL_WATCHDOG_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.rd_en      = rd_en;
    assign bus.rd_addr    = rd_addr;
    assign bus.cal_start  = state_q == S_LAUNCH;
    assign bus.i_idx      = i_q;
    assign bus.j_idx      = j_q;
    assign bus.a_wr_en    = state_q == S_WB1 || state_q == S_WB2;
    assign bus.a_wr_addr  = state_q == S_WB1 ? i_q : state_q == S_WB2 ? j_q : '0;
    assign bus.a_wr_data  = state_q == S_WB1 ? a1_q : state_q == S_WB2 ? a2_q : '0;
    assign bus.busy       = state_q != S_IDLE;
    assign bus.finish     = state_q == S_DONE;
    assign bus.converged  = conv_q;
    assign bus.timeout    = tmo_q;
    assign bus.iter_count = iter_q;
`ifdef SMO_CAL_WATCHDOG_EN
    assign bus.cal_err    = err_q;
`endif
endmodule
